// File: rtl/multicycle_control_unit_if.sv
// Handshake bundle between the fetch/datapath side and the multicycle control unit.
// The fetch stage drives run/IR/W_IR_valid; the control unit returns strobes and debug state.
interface multicycle_control_unit_if;
    logic        run;
    logic [31:0] IR;
    logic        W_IR_valid;
    logic        write_ir;
    logic        write_pc;
    logic [1:0]  pc_s;
    logic        write_reg;
    logic        rw_s;
    logic [1:0]  wd_s;
    logic        write_nzcv;
    logic [3:0]  alu_op;
    logic        alu_b_s;
    logic        mem_re;
    logic        mem_we;
    logic        instr_done;
    logic        illegal;
    logic [3:0]  state;

    // run is level-sensitive and only consulted at instruction boundaries; IR and
    // W_IR_valid must be stable from the edge that enters FETCH until instr_done.
    modport master (
        output run, IR, W_IR_valid,
        input  write_ir, write_pc, pc_s, write_reg, rw_s, wd_s, write_nzcv,
               alu_op, alu_b_s, mem_re, mem_we, instr_done, illegal, state
    );

    modport slave (
        input  run, IR, W_IR_valid,
        output write_ir, write_pc, pc_s, write_reg, rw_s, wd_s, write_nzcv,
               alu_op, alu_b_s, mem_re, mem_we, instr_done, illegal, state
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM for an ARM-like subset (data-processing, LDR/STR, B/BL).
// Strobes are registered together with the state so they are a pure function of the state register.
module multicycle_control_unit #(
    parameter int LINK_REG     = 14,
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input logic                      clk,
    input logic                      rst,
    multicycle_control_unit_if.slave bus
);

    if (LINK_REG < 0 || LINK_REG > 14) begin : g_link_reg_check
        $error("LINK_REG must name a general-purpose register (0-14)");
    end

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC     = 4'd3,
        S_WB       = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_TRAP     = 4'd15
    } state_t;

    typedef enum logic [1:0] {
        C_DP,
        C_MEM,
        C_BR,
        C_ILL
    } iclass_t;

    typedef struct packed {
        logic       write_ir;
        logic       write_pc;
        logic [1:0] pc_s;
        logic       write_reg;
        logic       rw_s;
        logic [1:0] wd_s;
        logic       write_nzcv;
        logic [3:0] alu_op;
        logic       alu_b_s;
        logic       mem_re;
        logic       mem_we;
        logic       instr_done;
    } strobe_t;

    state_t  state_q;
    state_t  next_state;
    state_t  boundary;
    iclass_t iclass;
    strobe_t strobe_q;
    strobe_t strobe_d;
    logic    illegal_q;
    logic    unused_ir;

    assign unused_ir = ^{bus.IR[31:28], bus.IR[19:16], bus.IR[11:8], bus.IR[6:5], bus.IR[3:0]};

    // Multiply/extra load-store space (I=0, bit7=1, bit4=1) is carved out of data-processing.
    always_comb begin
        iclass = C_ILL;
        if (bus.IR[27:26] == 2'b00 && !(!bus.IR[25] && bus.IR[7] && bus.IR[4]))
            iclass = C_DP;
        else if (bus.IR[27:26] == 2'b01)
            iclass = C_MEM;
        else if (bus.IR[27:25] == 3'b101)
            iclass = C_BR;
    end

    // instr_done marks the last state of an instruction, so every exit decision at a
    // boundary keys off the registered pulse rather than re-decoding IR.
    always_comb begin
        boundary   = bus.run ? S_FETCH : S_IDLE;
        next_state = state_q;
        if (strobe_q.instr_done) begin
            next_state = boundary;
        end else begin
            case (state_q)
                S_IDLE:     next_state = bus.run ? S_FETCH : S_IDLE;
                S_FETCH:    next_state = S_DECODE;
                S_DECODE: begin
                    case (iclass)
                        C_DP:    next_state = S_EXEC;
                        C_MEM:   next_state = S_MEM_ADDR;
                        C_BR:    next_state = S_BRANCH;
                        default: next_state = ILLEGAL_HALT ? S_TRAP : boundary;
                    endcase
                end
                S_EXEC:     next_state = S_WB;
                S_MEM_ADDR: next_state = bus.IR[20] ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:   next_state = S_MEM_WB;
                S_TRAP:     next_state = S_TRAP;
                default:    next_state = S_IDLE;
            endcase
        end
    end

    // Strobes for the state being entered; they land in strobe_q on the same edge as the state.
    always_comb begin
        strobe_d = '0;
        case (next_state)
            S_FETCH: begin
                strobe_d.write_ir   = bus.W_IR_valid;
                strobe_d.write_pc   = 1'b1;
                strobe_d.pc_s       = 2'b00;
                strobe_d.instr_done = !bus.W_IR_valid;
            end
            S_DECODE: begin
                strobe_d.instr_done = (iclass == C_ILL) && !ILLEGAL_HALT;
            end
            S_EXEC: begin
                strobe_d.alu_op     = bus.IR[24:21];
                strobe_d.alu_b_s    = bus.IR[25];
                strobe_d.write_nzcv = bus.IR[20] || (bus.IR[24:23] == 2'b10);
                strobe_d.instr_done = (bus.IR[24:23] == 2'b10);
            end
            S_WB: begin
                strobe_d.wd_s       = 2'b00;
                strobe_d.instr_done = 1'b1;
                if (bus.IR[15:12] == 4'hf) begin
                    strobe_d.write_pc = 1'b1;
                    strobe_d.pc_s     = 2'b10;
                end else begin
                    strobe_d.write_reg = 1'b1;
                    strobe_d.rw_s      = 1'b0;
                end
            end
            S_MEM_ADDR: begin
                strobe_d.alu_b_s = !bus.IR[25];
                strobe_d.alu_op  = bus.IR[23] ? 4'b0100 : 4'b0010;
            end
            S_MEM_RD: begin
                strobe_d.mem_re = 1'b1;
            end
            S_MEM_WB: begin
                strobe_d.write_reg  = 1'b1;
                strobe_d.rw_s       = 1'b0;
                strobe_d.wd_s       = 2'b01;
                strobe_d.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                strobe_d.mem_we     = 1'b1;
                strobe_d.instr_done = 1'b1;
            end
            S_BRANCH: begin
                strobe_d.write_pc   = 1'b1;
                strobe_d.pc_s       = 2'b01;
                strobe_d.instr_done = 1'b1;
                if (bus.IR[24]) begin
                    strobe_d.write_reg = 1'b1;
                    strobe_d.rw_s      = 1'b1;
                    strobe_d.wd_s      = 2'b10;
                end
            end
            default: strobe_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            strobe_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q  <= next_state;
            strobe_q <= strobe_d;
            if (state_q == S_DECODE && iclass == C_ILL)
                illegal_q <= 1'b1;
        end
    end

    assign bus.write_ir   = strobe_q.write_ir;
    assign bus.write_pc   = strobe_q.write_pc;
    assign bus.pc_s       = strobe_q.pc_s;
    assign bus.write_reg  = strobe_q.write_reg;
    assign bus.rw_s       = strobe_q.rw_s;
    assign bus.wd_s       = strobe_q.wd_s;
    assign bus.write_nzcv = strobe_q.write_nzcv;
    assign bus.alu_op     = strobe_q.alu_op;
    assign bus.alu_b_s    = strobe_q.alu_b_s;
    assign bus.mem_re     = strobe_q.mem_re;
    assign bus.mem_we     = strobe_q.mem_we;
    assign bus.instr_done = strobe_q.instr_done;
    assign bus.illegal    = illegal_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: each instruction is expanded into its expected per-cycle trace
// from the instruction-class rules, then compared cycle by cycle against the DUT.
module tb_multicycle_control_unit;

    localparam logic [3:0] ST_IDLE = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2, ST_EXEC = 4'd3,
                           ST_WB = 4'd4, ST_MEM_ADDR = 4'd5, ST_MEM_RD = 4'd6, ST_MEM_WB = 4'd7,
                           ST_MEM_WR = 4'd8, ST_BRANCH = 4'd9, ST_TRAP = 4'd15;

    typedef struct packed {
        logic [3:0]  st;
        logic [16:0] sv;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    multicycle_control_unit_if bus ();

    multicycle_control_unit #(
        .LINK_REG    (14),
        .ILLEGAL_HALT(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Field order: write_ir write_pc pc_s write_reg rw_s wd_s write_nzcv alu_op alu_b_s mem_re mem_we instr_done
    function automatic logic [16:0] mk(input logic wir, input logic wpc, input logic [1:0] pcs,
                                       input logic wreg, input logic rws, input logic [1:0] wds,
                                       input logic nzcv, input logic [3:0] op, input logic bs,
                                       input logic re, input logic we, input logic done);
        return {wir, wpc, pcs, wreg, rws, wds, nzcv, op, bs, re, we, done};
    endfunction

    function automatic logic [16:0] observed();
        return {bus.write_ir, bus.write_pc, bus.pc_s, bus.write_reg, bus.rw_s, bus.wd_s,
                bus.write_nzcv, bus.alu_op, bus.alu_b_s, bus.mem_re, bus.mem_we, bus.instr_done};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [3:0] st, input logic [16:0] sv, input logic ill);
        exp_t e;
        e.st  = st;
        e.sv  = sv;
        e.ill = ill;
        exp_q.push_back(e);
    endtask

    // Reference model: the cycle-by-cycle trace an instruction must produce.
    task automatic expand(input logic [31:0] ir, input logic valid);
        logic cmp;
        if (!valid) begin
            push(ST_FETCH, mk(0, 1, 2'd0, 0, 0, 2'd0, 0, 4'd0, 0, 0, 0, 1), 1'b0);
            return;
        end
        push(ST_FETCH, mk(1, 1, 2'd0, 0, 0, 2'd0, 0, 4'd0, 0, 0, 0, 0), 1'b0);
        push(ST_DECODE, 17'd0, 1'b0);
        if (ir[27:26] == 2'b00 && !(ir[25] == 1'b0 && ir[7] && ir[4])) begin
            cmp = (ir[24:21] >= 4'd8 && ir[24:21] <= 4'd11);
            push(ST_EXEC, mk(0, 0, 2'd0, 0, 0, 2'd0, ir[20] | cmp, ir[24:21], ir[25], 0, 0, cmp), 1'b0);
            if (!cmp) begin
                if (ir[15:12] == 4'd15)
                    push(ST_WB, mk(0, 1, 2'd2, 0, 0, 2'd0, 0, 4'd0, 0, 0, 0, 1), 1'b0);
                else
                    push(ST_WB, mk(0, 0, 2'd0, 1, 0, 2'd0, 0, 4'd0, 0, 0, 0, 1), 1'b0);
            end
        end else if (ir[27:26] == 2'b01) begin
            push(ST_MEM_ADDR, mk(0, 0, 2'd0, 0, 0, 2'd0, 0, ir[23] ? 4'd4 : 4'd2, ~ir[25], 0, 0, 0), 1'b0);
            if (ir[20]) begin
                push(ST_MEM_RD, mk(0, 0, 2'd0, 0, 0, 2'd0, 0, 4'd0, 0, 1, 0, 0), 1'b0);
                push(ST_MEM_WB, mk(0, 0, 2'd0, 1, 0, 2'd1, 0, 4'd0, 0, 0, 0, 1), 1'b0);
            end else begin
                push(ST_MEM_WR, mk(0, 0, 2'd0, 0, 0, 2'd0, 0, 4'd0, 0, 0, 1, 1), 1'b0);
            end
        end else if (ir[27:25] == 3'b101) begin
            push(ST_BRANCH, mk(0, 1, 2'd1, ir[24], ir[24], ir[24] ? 2'd2 : 2'd0, 0, 4'd0, 0, 0, 0, 1), 1'b0);
        end else begin
            push(ST_TRAP, 17'd0, 1'b1);
        end
    endtask

    // Called at a negedge; drop_at = cycle index after which run goes low, stop_after = cycles to run (0 = all).
    task automatic do_instr(input logic [31:0] ir, input logic valid, input int drop_at,
                            input int stop_after, input string name);
        exp_t e;
        int   n = 0;
        bit   run_now = 1'b1;
        bus.IR         = ir;
        bus.W_IR_valid = valid;
        bus.run        = 1'b1;
        exp_q.delete();
        expand(ir, valid);
        while (exp_q.size() > 0 && (stop_after == 0 || n < stop_after)) begin
            e = exp_q.pop_front();
            @(posedge clk);
            @(negedge clk);
            check($sformatf("%s.c%0d.state", name, n), 32'(bus.state), 32'(e.st));
            check($sformatf("%s.c%0d.strobes", name, n), 32'(observed()), 32'(e.sv));
            check($sformatf("%s.c%0d.illegal", name, n), 32'(bus.illegal), 32'(e.ill));
            if (n == drop_at) begin
                bus.run = 1'b0;
                run_now = 1'b0;
            end
            n++;
        end
        if (stop_after == 0 && !run_now) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("%s.idle_state", name), 32'(bus.state), 32'(ST_IDLE));
            check($sformatf("%s.idle_strobes", name), 32'(observed()), 32'd0);
        end
    endtask

    task automatic reset_and_check(input string name);
        rst     = 1'b1;
        bus.run = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({name, ".state"}, 32'(bus.state), 32'(ST_IDLE));
        check({name, ".strobes"}, 32'(observed()), 32'd0);
        check({name, ".illegal"}, 32'(bus.illegal), 32'd0);
        rst     = 1'b0;
        bus.run = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({name, ".idle_hold"}, 32'(bus.state), 32'(ST_IDLE));
    endtask

    initial begin
        logic [31:0] ir;
        logic        valid;
        int          drop;

        bus.run        = 1'b0;
        bus.IR         = 32'd0;
        bus.W_IR_valid = 1'b0;
        rst            = 1'b1;
        repeat (2) @(negedge clk);
        check("reset.state", 32'(bus.state), 32'(ST_IDLE));
        check("reset.strobes", 32'(observed()), 32'd0);
        check("reset.illegal", 32'(bus.illegal), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("idle_no_run", 32'(bus.state), 32'(ST_IDLE));

        do_instr(32'hE2811005, 1'b1, -1, 0, "add_imm");
        do_instr(32'hE3510000, 1'b1, -1, 0, "cmp");
        do_instr(32'hE5912004, 1'b1, -1, 0, "ldr");
        do_instr(32'hEB000003, 1'b1, -1, 0, "bl");
        do_instr(32'h0A000002, 1'b0, -1, 0, "beq_skip");
        do_instr(32'hEA000010, 1'b1, -1, 0, "b");
        do_instr(32'hE5812000, 1'b1, -1, 0, "str");
        do_instr(32'hE24FF004, 1'b1, -1, 0, "sub_pc");
        do_instr(32'hE0821003, 1'b1, -1, 0, "add_reg");
        do_instr(32'hE2811005, 1'b1, 2, 0, "run_drop_exec");
        @(posedge clk);
        @(negedge clk);
        check("run_drop.idle_stays", 32'(bus.state), 32'(ST_IDLE));

        for (int i = 0; i < 40; i++) begin
            ir = $urandom;
            case ($urandom_range(0, 2))
                0: begin
                    ir[27:26] = 2'b00;
                    if (!ir[25]) ir[4] = 1'b0;
                end
                1: ir[27:26] = 2'b01;
                default: ir[27:25] = 3'b101;
            endcase
            valid = ($urandom_range(0, 3) != 0);
            drop  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
            do_instr(ir, valid, drop, 0, $sformatf("rnd%0d", i));
        end

        do_instr(32'hE5912004, 1'b1, -1, 4, "ldr_to_memrd");
        reset_and_check("rst_in_memrd");

        do_instr(32'hEE000000, 1'b1, -1, 0, "illegal_cop");
        for (int i = 0; i < 3; i++) begin
            bus.run = i[0];
            @(posedge clk);
            @(negedge clk);
            check($sformatf("trap_hold%0d.state", i), 32'(bus.state), 32'(ST_TRAP));
            check($sformatf("trap_hold%0d.strobes", i), 32'(observed()), 32'd0);
            check($sformatf("trap_hold%0d.illegal", i), 32'(bus.illegal), 32'd1);
        end
        reset_and_check("rst_in_trap");

        do_instr(32'hE0010291, 1'b1, -1, 0, "illegal_mul");
        reset_and_check("rst_after_mul");
        do_instr(32'hE3510000, 1'b1, -1, 0, "cmp_after_trap");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
